// File: rtl/dircc_node_processing_mem_reader.sv
// Avalon-MM read master for the 16-bit second port of a node processing memory.
// Streams LEN words starting at BASE out on an Avalon-ST source with sop/eop framing,
// so node hardware can drain messages without a CPU copy loop.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, base, len             transfer request (base/len sampled with start)
//   busy, done, err              status; done/err are one-cycle pulses
//   mem_*                        Avalon-MM read master (1-cycle fixed read latency)
//   out_data/valid/ready/sop/eop Avalon-ST source
//   csum                         only with DIRCC_MEM_READER_CSUM_EN defined: ones-complement
//                                sum of all streamed words of the last transfer
//
// Optional feature macro: DIRCC_MEM_READER_CSUM_EN
module dircc_node_processing_mem_reader #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 15000,
  parameter int unsigned LEN_W      = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
`ifdef DIRCC_MEM_READER_CSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W:0]    DepthLen = (LEN_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;    // reads still to issue
  logic              first_q;     // next read issued carries sop
  logic              inflight_q;  // read issued last cycle, data on mem_readdata now
  logic              infl_sop_q, infl_eop_q;
  logic              done_q, err_q;

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic              fifo_sop_q  [FIFO_DEPTH];
  logic              fifo_eop_q  [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic bad_req, start_ok, room, issue, last_issue, pop, pop_eop;

  assign bad_req    = (base > LastAddr) || ({1'b0, len} > DepthLen);
  assign start_ok   = start && (state_q == StIdle) && !bad_req;
  // Reserve a slot for the in-flight read so the memory never has to stall.
  assign room       = (count_q + CntW'(inflight_q)) < CntW'(FIFO_DEPTH);
  assign issue      = mem_chipselect;
  assign last_issue = issue && (remain_q == LEN_W'(1));
  assign pop        = out_valid && out_ready;
  assign pop_eop    = pop && out_eop;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok && (len != '0)) state_d = StRead;
      StRead:  if (last_issue) state_d = StDrain;
      StDrain: if (pop_eop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy           = (state_q != StIdle);
    mem_chipselect = (state_q == StRead) && room;
  end

  assign mem_address    = addr_q;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;
  assign done           = done_q;
  assign err            = err_q;
  assign out_valid      = (count_q != '0);
  assign out_data       = fifo_data_q[rd_ptr_q];
  assign out_sop        = out_valid && fifo_sop_q[rd_ptr_q];
  assign out_eop        = out_valid && fifo_eop_q[rd_ptr_q];

  // Read issue and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      remain_q   <= '0;
      first_q    <= 1'b0;
      inflight_q <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= (start_ok && (len == '0)) || pop_eop;
      err_q      <= start && (state_q == StIdle) && bad_req;
      inflight_q <= issue;
      infl_sop_q <= issue && first_q;
      infl_eop_q <= last_issue;
      if (start_ok) begin
        addr_q   <= base;
        remain_q <= len;
        first_q  <= 1'b1;
      end else if (issue) begin
        // Wrap at the memory depth, not at the address-width boundary.
        addr_q   <= (addr_q == LastAddr) ? '0 : addr_q + ADDR_W'(1);
        remain_q <= remain_q - LEN_W'(1);
        first_q  <= 1'b0;
      end
    end
  end

  // Output FIFO; written unconditionally when read data returns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_sop_q[i]  <= 1'b0;
        fifo_eop_q[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= mem_readdata;
        fifo_sop_q[wr_ptr_q]  <= infl_sop_q;
        fifo_eop_q[wr_ptr_q]  <= infl_eop_q;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({inflight_q, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DIRCC_MEM_READER_CSUM_EN
  logic [15:0] csum_q;
  logic [16:0] csum_sum;

  assign csum_sum = {1'b0, csum_q} + {1'b0, out_data[15:0]};
  assign csum     = csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (pop) begin
      // End-around carry
      csum_q <= csum_sum[15:0] + {15'b0, csum_sum[16]};
    end
  end
`endif

endmodule
